// File: rtl/reg_pipeline_if.sv
// Handshake bundle for reg_pipeline: upstream valid/ready/data, downstream valid/ready/data, occupancy.
// Flush port exists only when REG_PIPELINE_FLUSH_EN is defined.
interface reg_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
`ifdef REG_PIPELINE_FLUSH_EN
  logic             flush;

  modport master (output in_valid, in_data, out_ready, flush,
                  input  in_ready, out_valid, out_data, count);
  modport slave  (input  in_valid, in_data, out_ready, flush,
                  output in_ready, out_valid, out_data, count);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, count);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, count);
`endif
endinterface

// File: rtl/reg_pipeline.sv
// WIDTH x DEPTH register pipeline with valid/ready, bubble collapsing and occupancy count.
// Optional synchronous flush enabled by macro REG_PIPELINE_FLUSH_EN.
module reg_pipeline #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  reg_pipeline_if.slave p
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d, adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             flush_w, xfer_in, xfer_out, tail_full;

`ifdef REG_PIPELINE_FLUSH_EN
  assign flush_w = p.flush;
`else
  assign flush_w = 1'b0;
`endif

  // A stage stalls only when it and every stage after it are full and the output is blocked.
  always_comb begin
    tail_full = 1'b1;
    adv       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v_q[i];
      adv[i]    = !tail_full | p.out_ready;
    end
  end

  assign p.in_ready  = adv[0] & !flush_w;
  assign p.out_valid = v_q[DEPTH-1] & !flush_w;
  assign p.out_data  = d_q[DEPTH-1];
  assign p.count     = count_q;
  assign xfer_in     = p.in_valid & p.in_ready;
  assign xfer_out    = p.out_valid & p.out_ready;

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q + CW'(xfer_in) - CW'(xfer_out);
    if (adv[0]) begin
      v_d[0] = p.in_valid;
      if (xfer_in) d_d[0] = p.in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
    end
    // Flush drops every beat but leaves the data registers untouched.
    if (flush_w) begin
      v_d     = '0;
      d_d     = d_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VAL;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      d_q     <= d_d;
    end
  end
endmodule
